// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the operand dispatch stage that feeds it.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;
  localparam logic [3:0] ALU_MUL = 4'd9;
  localparam logic [3:0] ALU_INC = 4'd10;
  localparam logic [3:0] ALU_DEC = 4'd11;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } dispatch_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Small resettable register file: two async read ports, an external load port
// and a writeback port; writeback wins when both target the same entry.
module alu_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_AW-1:0]     rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [REG_AW-1:0]     rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  ext_we,
  input  logic [REG_AW-1:0]     ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_data,
  input  logic                  wb_we,
  input  logic [REG_AW-1:0]     wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic [NUM_REGS-1:0]   ext_sel;
  logic [NUM_REGS-1:0]   wb_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
      assign ext_sel[gi] = ext_we && (ext_addr == REG_AW'(gi));
      assign wb_sel[gi]  = wb_we && (wb_addr == REG_AW'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
      if (ext_sel[i]) mem_d[i] = ext_data;
      // Writeback is evaluated last so it overrides a colliding external load.
      if (wb_sel[i]) mem_d[i] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) mem_q[i] <= '0;
      else     mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/alu_operand_dispatch.sv
// Command sequencer in front of the combinational ALU: fetch operands, hold them
// stable for one execute cycle, capture result/flags, write back and respond.
module alu_operand_dispatch
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int NUM_REGS     = 8,
  localparam int REG_AW      = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [REG_AW-1:0]       cmd_rd,
  input  logic [REG_AW-1:0]       cmd_rs1,
  input  logic [REG_AW-1:0]       cmd_rs2,
  input  logic                    cmd_use_imm,
  input  logic [DATA_WIDTH-1:0]   cmd_imm,
  input  logic                    cmd_wb,
  input  logic                    wr_en,
  input  logic [REG_AW-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_carry,
  input  logic                    alu_overflow,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_result,
  output logic [2:0]              rsp_flags
);

  dispatch_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [OPCODE_WIDTH-1:0] alu_opcode_q, alu_opcode_d;
  logic [REG_AW-1:0]       rd_q, rd_d;
  logic                    wb_q, wb_d;
  logic [DATA_WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic [2:0]              rsp_flags_q, rsp_flags_d;
  logic [DATA_WIDTH-1:0]   rf_data_a;
  logic [DATA_WIDTH-1:0]   rf_data_b;
  logic                    wb_we;

  alu_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr_a(cmd_rs1),
    .rd_data_a(rf_data_a),
    .rd_addr_b(cmd_rs2),
    .rd_data_b(rf_data_b),
    .ext_we   (wr_en),
    .ext_addr (wr_addr),
    .ext_data (wr_data),
    .wb_we    (wb_we),
    .wb_addr  (rd_q),
    .wb_data  (alu_result)
  );

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    rd_d         = rd_q;
    wb_d         = wb_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    // External loads take the regfile port priority over command acceptance.
    cmd_ready    = (state_q == ST_IDLE) && !wr_en && !rst;
    wb_we        = (state_q == ST_EXEC) && wb_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d      = rf_data_a;
          alu_b_d      = cmd_use_imm ? cmd_imm : rf_data_b;
          alu_opcode_d = cmd_opcode;
          rd_d         = cmd_rd;
          wb_d         = cmd_wb;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d            = alu_result;
        rsp_flags_d[FLAG_ZERO]  = alu_zero;
        rsp_flags_d[FLAG_CARRY] = alu_carry;
        rsp_flags_d[FLAG_OVF]   = alu_overflow;
        state_d                 = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      rd_q         <= '0;
      wb_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      rd_q         <= rd_d;
      wb_q         <= wb_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule
